// File: rtl/sprite_pkg.sv
// Shared sprite-path definitions: default ROM geometry, the transparent colour key
// and the round-robin pointer wrap helper.
package sprite_pkg;

    localparam int unsigned ADDRESS_DEF    = 10;
    localparam int unsigned COLOR_BITS_DEF = 24;

    localparam logic [COLOR_BITS_DEF-1:0] TRANSPARENT_DEF = 24'hFF00FF;

    typedef logic [COLOR_BITS_DEF-1:0] rgb_t;

    // Next pointer after serving index i; explicit wrap so non-power-of-2 counts work
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return ((i + 1) >= n) ? 0 : (i + 1);
    endfunction

endpackage : sprite_pkg

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin pick: first set request at or after ptr_i,
// wrapping N-1 -> 0. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int unsigned IDX_W = $clog2(N);

    int unsigned j;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[IDX_W'(j)]) begin
                found               = 1'b1;
                gnt_o[IDX_W'(j)]    = 1'b1;
                idx_o               = IDX_W'(j);
            end
        end
        any_o = found;
    end

endmodule : rr_arbiter

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one async-read sprite colour ROM among NUM_REQ renderers:
// grant, registered ROM address, registered data return tagged with id and transparency.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned           NUM_REQ     = 4,
    parameter int unsigned           ADDRESS     = ADDRESS_DEF,
    parameter int unsigned           COLOR_BITS  = COLOR_BITS_DEF,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT = COLOR_BITS'(TRANSPARENT_DEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDRESS-1:0]   req_addr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [ADDRESS-1:0]           rom_addr,
    input  logic [COLOR_BITS-1:0]        rom_dout,
    output logic                         rdata_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rdata_id,
    output logic [COLOR_BITS-1:0]        rdata,
    output logic                         rdata_transp
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_eff;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [ADDRESS-1:0]    sel_addr;

    logic [IDX_W-1:0]      ptr_q,          ptr_d;
    logic [ADDRESS-1:0]    rom_addr_q,     rom_addr_d;
    logic                  s1_valid_q,     s1_valid_d;
    logic [IDX_W-1:0]      s1_id_q,        s1_id_d;
    logic                  rdata_valid_q,  rdata_valid_d;
    logic [IDX_W-1:0]      rdata_id_q,     rdata_id_d;
    logic [COLOR_BITS-1:0] rdata_q,        rdata_d;
    logic                  rdata_transp_q, rdata_transp_d;

    // No grants while disabled or held in reset; in-flight reads still drain
    assign req_eff = (en && rst_n) ? req : '0;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_addr = req_addr[i*ADDRESS +: ADDRESS];
        end
    end

    // Next-state for pointer and both pipeline stages
    always_comb begin
        ptr_d          = ptr_q;
        rom_addr_d     = rom_addr_q;
        s1_valid_d     = 1'b0;
        s1_id_d        = s1_id_q;
        rdata_valid_d  = s1_valid_q;
        rdata_id_d     = rdata_id_q;
        rdata_d        = rdata_q;
        rdata_transp_d = rdata_transp_q;

        if (gnt_any) begin
            ptr_d      = IDX_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
            rom_addr_d = sel_addr;
            s1_valid_d = 1'b1;
            s1_id_d    = gnt_idx;
        end

        if (s1_valid_q) begin
            rdata_id_d     = s1_id_q;
            rdata_d        = rom_dout;
            rdata_transp_d = (rom_dout == TRANSPARENT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            rom_addr_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_id_q        <= '0;
            rdata_valid_q  <= 1'b0;
            rdata_id_q     <= '0;
            rdata_q        <= '0;
            rdata_transp_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            rom_addr_q     <= rom_addr_d;
            s1_valid_q     <= s1_valid_d;
            s1_id_q        <= s1_id_d;
            rdata_valid_q  <= rdata_valid_d;
            rdata_id_q     <= rdata_id_d;
            rdata_q        <= rdata_d;
            rdata_transp_q <= rdata_transp_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rdata_valid  = rdata_valid_q;
    assign rdata_id     = rdata_id_q;
    assign rdata        = rdata_q;
    assign rdata_transp = rdata_transp_q;

endmodule : sprite_rom_arbiter

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: a round-robin reference model predicts
// grants and queues the expected ROM returns, which are checked when they come out.
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned CW = 24;
    localparam logic [CW-1:0] TRANSP = TRANSPARENT_DEF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     gnt;
    logic [AW-1:0]     rom_addr;
    logic [CW-1:0]     rom_dout;
    logic              rdata_valid;
    logic [1:0]        rdata_id;
    logic [CW-1:0]     rdata;
    logic              rdata_transp;

    rgb_t mem [1<<AW];
    assign rom_dout = mem[rom_addr];

    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .NUM_REQ    (NR),
        .ADDRESS    (AW),
        .COLOR_BITS (CW),
        .TRANSPARENT(TRANSP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout),
        .rdata_valid  (rdata_valid),
        .rdata_id     (rdata_id),
        .rdata        (rdata),
        .rdata_transp (rdata_transp)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    typedef struct {
        int      due;
        int      id;
        rgb_t    data;
        logic    transp;
    } exp_t;

    exp_t          sb[$];
    int            ptr_m      = 0;
    logic [NR-1:0] gnt_m_last = '0;
    bit            armed      = 1'b0;
    bit            rst_prev   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model + scoreboard, evaluated mid-cycle
    always @(negedge clk) begin : monitor
        logic [NR-1:0] g_exp;
        logic [AW-1:0] a;
        exp_t          e;
        bit            ev;
        int            j;
        if (armed) begin
            g_exp = '0;
            if (rst_n && en) begin
                for (int k = 0; k < NR; k++) begin
                    j = (ptr_m + k) % NR;
                    if (req[j] && g_exp == '0) g_exp[j] = 1'b1;
                end
            end
            check_eq("gnt", 32'(gnt), 32'(g_exp));
            for (int i = 0; i < NR; i++) begin
                if (g_exp[i]) begin
                    a        = req_addr[i*AW +: AW];
                    e.due    = cyc + 2;
                    e.id     = i;
                    e.data   = mem[a];
                    e.transp = (mem[a] == TRANSP);
                    sb.push_back(e);
                    ptr_m    = (i + 1) % NR;
                end
            end
            gnt_m_last = g_exp;

            ev = (sb.size() > 0) && (sb[0].due == cyc);
            check_eq("rdata_valid", 32'(rdata_valid), 32'(ev));
            if (ev) begin
                e = sb.pop_front();
                if (rdata_valid) begin
                    check_eq("rdata_id", 32'(rdata_id), 32'(e.id));
                    check_eq("rdata", 32'(rdata), 32'(e.data));
                    check_eq("rdata_transp", 32'(rdata_transp), 32'(e.transp));
                end
            end

            if (rst_prev) check_eq("rom_addr_rst", 32'(rom_addr), 32'd0);
            if (!rst_n) begin
                sb.delete();
                ptr_m = 0;
            end
            rst_prev = !rst_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = rgb_t'((a * 32'h0001_0307) ^ 32'h00A5_5A3C);
        mem[5] = TRANSP;
        mem[6] = 24'h00FF00;

        // Reset held with all requests asserted
        rst_n = 1'b0;
        en    = 1'b1;
        req   = '1;
        req_addr = '0;
        set_addr(0, 10'd10); set_addr(1, 10'd20); set_addr(2, 10'd30); set_addr(3, 10'd40);
        step();
        armed = 1'b1;
        step();
        rst_n = 1'b1;

        // Full contention
        repeat (8) step();

        // Pointer wrap: grant 3, then 4'b1001 -> 0 then 3
        req = 4'b1000;
        step();
        req = 4'b1001;
        step();
        step();
        req = '0;

        // Transparency key vs opaque colour
        req = 4'b0001;
        set_addr(0, 10'd5);
        step();
        set_addr(0, 10'd6);
        step();
        req = '0;
        repeat (3) step();

        // en drop right after a grant; pointer must resume
        req = 4'b0010;
        set_addr(1, 10'd7);
        step();
        en  = 1'b0;
        req = '1;
        repeat (3) step();
        en = 1'b1;
        step();
        step();
        req = '0;
        repeat (3) step();

        // Reset one cycle after a grant discards the in-flight read
        req = '1;
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        req = '0;
        repeat (3) step();

        // Random traffic obeying the hold-until-granted handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] || gnt_m_last[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[i] = 1'b1;
                        if ($urandom_range(0, 7) == 0) set_addr(i, AW'(5 + $urandom_range(0, 1)));
                        else                           set_addr(i, AW'($urandom_range(0, (1 << AW) - 1)));
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            en = ($urandom_range(0, 9) != 0);
            step();
        end

        req = '0;
        en  = 1'b1;
        repeat (4) step();
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sprite_rom_arbiter
